// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared state encoding and defaults for the pipeline hazard controller
package pipe_ctrl_pkg;

    localparam int STATE_W             = 2;
    localparam int TIMER_W             = 5;
    localparam int MEM_TIMEOUT_DEFAULT = 16;

    typedef enum logic [STATE_W-1:0] {
        ST_INIT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_ERROR    = 2'd3
    } pipe_state_e;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - load-use comparator between the ID sources and the EX destination
module hazard_detect (
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_memtoreg,
    input  logic       ex_regwrite,
    output logic       load_use
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit  = id_uses_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit  = id_uses_rs2 && (id_rs2 == ex_rd);
    // x0 is hardwired to zero, so a load targeting it never creates a dependency
    assign load_use = ex_memtoreg && ex_regwrite && (ex_rd != 5'd0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline stall/flush controller; PIPE_PERF_CNT_EN adds stall/flush counters
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [4:0]         id_rs1,
    input  logic [4:0]         id_rs2,
    input  logic               id_uses_rs1,
    input  logic               id_uses_rs2,
    input  logic [4:0]         ex_rd,
    input  logic               ex_memtoreg,
    input  logic               ex_regwrite,
    input  logic               ex_branch_taken,
    input  logic               mem_req,
    input  logic               mem_ack,
    output logic               pc_write,
    output logic               ifid_write,
    output logic               ifid_flush,
    output logic               idex_flush,
    output logic               idex_hold,
    output logic               exmem_hold,
    output logic               mem_timeout,
`ifdef PIPE_PERF_CNT_EN
    output logic [31:0]        stall_cnt,
    output logic [31:0]        flush_cnt,
`endif
    output logic [STATE_W-1:0] state
);

    localparam logic [TIMER_W-1:0] TIMEOUT_VAL = TIMER_W'(MEM_TIMEOUT);

    pipe_state_e        state_q;
    pipe_state_e        state_d;
    logic [TIMER_W-1:0] timer_q;
    logic [TIMER_W-1:0] timer_d;
    logic               load_use;
    logic               mem_stall;
    logic               run_pc_write;
    logic               run_ifid_write;
    logic               run_ifid_flush;
    logic               run_idex_flush;

    hazard_detect u_hazard_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_rd       (ex_rd),
        .ex_memtoreg (ex_memtoreg),
        .ex_regwrite (ex_regwrite),
        .load_use    (load_use)
    );

    assign mem_stall = mem_req && !mem_ack;

    // Normal-flow decode, shared by RUN and the MEM_WAIT ack cycle
    always_comb begin
        run_pc_write   = 1'b1;
        run_ifid_write = 1'b1;
        run_ifid_flush = 1'b0;
        run_idex_flush = 1'b0;
        if (ex_branch_taken) begin
            run_ifid_flush = 1'b1;
            run_idex_flush = 1'b1;
        end else if (load_use) begin
            run_pc_write   = 1'b0;
            run_ifid_write = 1'b0;
            run_idex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_INIT;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        idex_hold  = 1'b0;
        exmem_hold = 1'b0;
        unique case (state_q)
            ST_INIT: begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                timer_d    = '0;
                state_d    = ST_RUN;
            end
            ST_RUN: begin
                if (mem_stall) begin
                    idex_hold  = 1'b1;
                    exmem_hold = 1'b1;
                    timer_d    = TIMER_W'(1);
                    state_d    = ST_MEM_WAIT;
                end else begin
                    pc_write   = run_pc_write;
                    ifid_write = run_ifid_write;
                    ifid_flush = run_ifid_flush;
                    idex_flush = run_idex_flush;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ack) begin
                    pc_write   = run_pc_write;
                    ifid_write = run_ifid_write;
                    ifid_flush = run_ifid_flush;
                    idex_flush = run_idex_flush;
                    timer_d    = '0;
                    state_d    = ST_RUN;
                end else begin
                    idex_hold  = 1'b1;
                    exmem_hold = 1'b1;
                    // Timeout is checked before incrementing so the timer never wraps
                    if (timer_q == TIMEOUT_VAL) begin
                        state_d = ST_ERROR;
                    end else begin
                        timer_d = timer_q + TIMER_W'(1);
                    end
                end
            end
            ST_ERROR: begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    assign mem_timeout = (state_q == ST_ERROR);
    assign state       = state_q;

`ifdef PIPE_PERF_CNT_EN
    logic active;
    logic branch_apply;

    assign active       = (state_q == ST_RUN) || (state_q == ST_MEM_WAIT);
    assign branch_apply = ex_branch_taken &&
                          (((state_q == ST_RUN) && !mem_stall) ||
                           ((state_q == ST_MEM_WAIT) && mem_ack));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (active && !pc_write) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (branch_apply) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
